// File: rtl/fft_output_reorder_pkg.sv
// Shared constants, page/FSM encodings and the bit-reverse helper for the
// FFT output reorder buffer.
package fft_output_reorder_pkg;

  localparam int LOG2N = 6;
  localparam int N     = 1 << LOG2N;

  typedef enum logic [1:0] {
    PG_EMPTY    = 2'd0,
    PG_FILLING  = 2'd1,
    PG_FULL     = 2'd2,
    PG_DRAINING = 2'd3
  } page_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_t;

  // Reverse the low 'bits' bits of v (bits <= 16).
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int bits);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r >> (16 - bits);
  endfunction

endpackage

// File: rtl/fft_output_reorder_if.sv
// Handshake/data bundle between the FFT core, the reorder buffer and the
// natural-order consumer.
interface fft_output_reorder_if #(
  parameter int BW    = 16,
  parameter int LOG2N = fft_output_reorder_pkg::LOG2N
);
  logic             in_valid;
  logic [BW-1:0]    in_re0, in_im0, in_re1, in_im1;
  logic             out_valid;
  logic             out_ready;
  logic [BW-1:0]    out_re, out_im;
  logic [LOG2N-1:0] out_index;
  logic             out_last;
  logic             overflow;

  modport master (
    output in_valid, in_re0, in_im0, in_re1, in_im1, out_ready,
    input  out_valid, out_re, out_im, out_index, out_last, overflow
  );

  modport slave (
    input  in_valid, in_re0, in_im0, in_re1, in_im1, out_ready,
    output out_valid, out_re, out_im, out_index, out_last, overflow
  );
endinterface

// File: rtl/fft_output_reorder_page_ram.sv
// One reorder page: two write ports, one synchronous read port whose output
// register holds while re is low.
module reorder_page_ram #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa0,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [1 << AW];

  // wa0 and wa1 are always distinct bins of the same pair.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa0] <= wd0;
      mem[wa1] <= wd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     rd <= '0;
    else if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output pairs in, natural-order
// samples out on a valid/ready stream; frames are dropped when both pages are busy.
//
// state   | meaning
// W_IDLE  | waiting for pair 0 of a frame
// W_FILL  | writing pairs 1..N/2-1 (or discarding them if the frame was dropped)
// R_IDLE  | next fetch is bin 0 of page r_ptr once that page is FULL
// R_DRAIN | fetching bins 1..N-1 of page r_ptr
module fft_output_reorder #(
  parameter int BW    = 16,
  parameter int LOG2N = fft_output_reorder_pkg::LOG2N
) (
  input logic clk,
  input logic rst,
  fft_output_reorder_if.slave bus
);
  import fft_output_reorder_pkg::*;

  typedef logic [LOG2N-2:0] pair_t;

  page_state_t      pg_state [2];
  wr_state_t        w_state;
  rd_state_t        r_state;
  logic             w_ptr, w_drop, r_ptr, out_page;
  pair_t            w_cnt;
  logic [LOG2N-1:0] r_addr, out_index_q, wa0, wa1;
  logic             out_valid_q, out_last_q, overflow_q;
  logic             xfer_last, advance, fetch, wr_en;
  logic [1:0]       page_free;
  logic [2*BW-1:0]  rd_data [2];

  assign xfer_last = out_valid_q && bus.out_ready && out_last_q;
  assign advance   = !out_valid_q || bus.out_ready;
  assign fetch     = advance && (r_state == R_DRAIN || pg_state[r_ptr] == PG_FULL);

  // A draining page counts as free in the cycle its last bin is accepted.
  always_comb begin
    for (int p = 0; p < 2; p++)
      page_free[p] = (pg_state[p] == PG_EMPTY) ||
                     (pg_state[p] == PG_DRAINING && xfer_last && out_page == p[0]);
  end

  assign wr_en = bus.in_valid && ((w_state == W_IDLE) ? page_free[w_ptr] : !w_drop);
  assign wa0   = LOG2N'(bitrev(16'({w_cnt, 1'b0}), LOG2N));
  assign wa1   = LOG2N'(bitrev(16'({w_cnt, 1'b1}), LOG2N));

  for (genvar p = 0; p < 2; p++) begin : g_page
    reorder_page_ram #(.DW(2*BW), .AW(LOG2N)) u_ram (
      .clk (clk),
      .rst (rst),
      .we  (wr_en && w_ptr == 1'(p)),
      .wa0 (wa0),
      .wa1 (wa1),
      .wd0 ({bus.in_re0, bus.in_im0}),
      .wd1 ({bus.in_re1, bus.in_im1}),
      .re  (fetch && r_ptr == 1'(p)),
      .ra  (r_addr),
      .rd  (rd_data[p])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pg_state[0] <= PG_EMPTY;
      pg_state[1] <= PG_EMPTY;
      w_state     <= W_IDLE;
      r_state     <= R_IDLE;
      w_ptr       <= 1'b0;
      w_drop      <= 1'b0;
      w_cnt       <= '0;
      r_ptr       <= 1'b0;
      r_addr      <= '0;
      out_page    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (advance) begin
        out_valid_q <= fetch;
        out_last_q  <= fetch && (&r_addr);
        if (fetch) begin
          out_index_q <= r_addr;
          out_page    <= r_ptr;
        end
      end

      if (xfer_last) pg_state[out_page] <= PG_EMPTY;

      if (fetch) begin
        if (r_state == R_IDLE) pg_state[r_ptr] <= PG_DRAINING;
        if (&r_addr) begin
          r_state <= R_IDLE;
          r_addr  <= '0;
          r_ptr   <= ~r_ptr;
        end else begin
          r_state <= R_DRAIN;
          r_addr  <= r_addr + 1'b1;
        end
      end

      // Write-side updates come last so a page refilled in its free cycle ends up FILLING.
      case (w_state)
        W_IDLE: if (bus.in_valid) begin
          w_state <= W_FILL;
          w_cnt   <= pair_t'(1);
          if (page_free[w_ptr]) begin
            pg_state[w_ptr] <= PG_FILLING;
            w_drop          <= 1'b0;
          end else begin
            w_drop     <= 1'b1;
            overflow_q <= 1'b1;
          end
        end
        W_FILL: if (bus.in_valid) begin
          if (&w_cnt) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            if (!w_drop) begin
              pg_state[w_ptr] <= PG_FULL;
              w_ptr           <= ~w_ptr;
            end
          end else begin
            w_cnt <= w_cnt + 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = rd_data[out_page][2*BW-1:BW];
  assign bus.out_im    = rd_data[out_page][BW-1:0];
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed/randomized bench for fft_output_reorder against a natural-order
// frame model.
module tb_fft_output_reorder;
  localparam int BW    = 16;
  localparam int LOG2N = 6;
  localparam int N     = 1 << LOG2N;
  localparam int NP    = N / 2;

  typedef logic [2*BW+LOG2N:0] smp_t;  // {last, index, re, im}

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0, n_fail = 0;
  int   cyc_cnt = 0;
  bit   rand_ready = 1'b0;

  logic [BW-1:0] fre [4][N];
  logic [BW-1:0] fim [4][N];
  smp_t exp_q[$];
  smp_t got[$];
  int   stamps[$];
  smp_t cur, held;
  bit   stalled = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  fft_output_reorder_if #(.BW(BW), .LOG2N(LOG2N)) bus ();
  fft_output_reorder #(.BW(BW), .LOG2N(LOG2N)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign cur = {bus.out_last, bus.out_index, bus.out_re, bus.out_im};

  // Records every transfer and checks that a stalled sample holds.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        n_tests++;
        assert (bus.out_valid === 1'b1 && cur === held) else begin
          n_fail++;
          $error("FAIL stall_hold: observed %h valid %b, expected %h valid 1", cur, bus.out_valid, held);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got.push_back(cur);
        stamps.push_back(cyc_cnt);
      end
      stalled = (bus.out_valid === 1'b1 && bus.out_ready === 1'b0);
      held    = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rev(input int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill_bins(input int f);
    for (int b = 0; b < N; b++) begin
      fre[f][b] = BW'(b);
      fim[f][b] = BW'(b) | 16'h8000;
    end
  endtask

  task automatic fill_rand(input int f);
    for (int b = 0; b < N; b++) begin
      fre[f][b] = BW'($urandom);
      fim[f][b] = BW'($urandom);
    end
  endtask

  task automatic push_exp(input int f);
    for (int b = 0; b < N; b++)
      exp_q.push_back({1'(b == N-1), LOG2N'(b), fre[f][b], fim[f][b]});
  endtask

  task automatic send_pairs(input int f, input int k0, input int k1, input bit gap);
    for (int k = k0; k <= k1; k++) begin
      bus.in_valid = 1'b1;
      bus.in_re0 = fre[f][rev(2*k)];
      bus.in_im0 = fim[f][rev(2*k)];
      bus.in_re1 = fre[f][rev(2*k+1)];
      bus.in_im1 = fim[f][rev(2*k+1)];
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (gap) begin
        bus.in_valid = 1'b0;
        bus.in_re0 = BW'($urandom);
        bus.in_im1 = BW'($urandom);
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_last_xfer(input string tag);
    int cyc = 0;
    while (!(bus.out_valid === 1'b1 && bus.out_last === 1'b1 && bus.out_ready === 1'b1) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    assert (cyc < 500) else begin
      n_fail++;
      $error("FAIL %s: bin %0d transfer not seen within %0d cycles", tag, N-1, cyc);
    end
  endtask

  task automatic check_outputs(input int n, input string tag, input bit nobubble);
    int   cyc = 0;
    int   s, fs = 0;
    smp_t o, e;
    while (got.size() < n && cyc < 3000) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    assert (got.size() >= n) else begin
      n_fail++;
      $error("FAIL %s_count: observed %0d samples, expected %0d", tag, got.size(), n);
    end
    for (int i = 0; i < n && got.size() > 0; i++) begin
      o = got.pop_front();
      s = stamps.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s sample %0d: observed %h expected %h", tag, i, o, e);
      end
      if (i % N == 0) fs = s;
      if (nobubble && i % N == N-1) begin
        n_tests++;
        assert (s - fs === N-1) else begin
          n_fail++;
          $error("FAIL %s_bubbles: frame span observed %0d cycles, expected %0d", tag, s - fs, N-1);
        end
      end
    end
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    assert (got.size() === 0) else begin
      n_fail++;
      $error("FAIL %s_extra: observed %0d extra samples, expected 0", tag, got.size());
    end
    got.delete();
    stamps.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_re0    = '0;
    bus.in_im0    = '0;
    bus.in_re1    = '0;
    bus.in_im1    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last",  64'(bus.out_last),  64'd0);
    chk("rst_overflow",  64'(bus.overflow),  64'd0);
    chk("rst_out_re",    64'(bus.out_re),    64'd0);
    chk("rst_out_im",    64'(bus.out_im),    64'd0);
    chk("rst_out_index", 64'(bus.out_index), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single frame, value = bin number, with exact latency.
    bus.out_ready = 1'b1;
    fill_bins(0);
    push_exp(0);
    send_pairs(0, 0, NP-1, 1'b0);
    @(negedge clk);
    chk("latency_t1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("latency_t2_valid", 64'(bus.out_valid), 64'd1);
    chk("latency_t2_index", 64'(bus.out_index), 64'd0);
    check_outputs(N, "single", 1'b1);

    // Same frame with in_valid toggling 1,0.
    push_exp(0);
    send_pairs(0, 0, NP-1, 1'b1);
    check_outputs(N, "gapped", 1'b1);

    // Random data under 50% random backpressure.
    fill_rand(1);
    push_exp(1);
    rand_ready = 1'b1;
    send_pairs(1, 0, NP-1, 1'b0);
    rand_ready = 1'b1;
    check_outputs(N, "backpressure", 1'b0);

    // Back-to-back: frame 2 starts the cycle frame 1's last bin transfers.
    bus.out_ready = 1'b1;
    fill_rand(0);
    fill_rand(1);
    fill_rand(2);
    push_exp(0);
    push_exp(1);
    push_exp(2);
    send_pairs(0, 0, NP-1, 1'b0);
    wait_last_xfer("b2b_first_last");
    send_pairs(1, 0, NP-1, 1'b0);
    send_pairs(2, 0, NP-1, 1'b0);
    check_outputs(3*N, "b2b", 1'b1);
    chk("b2b_overflow", 64'(bus.overflow), 64'd0);

    // Overflow: three frames with no acceptance, the third is dropped.
    // Frame 4 then starts in the cycle page 0 frees while page 1 is still FULL.
    bus.out_ready = 1'b0;
    for (int f = 0; f < 4; f++) fill_rand(f);
    push_exp(0);
    push_exp(1);
    push_exp(3);
    send_pairs(0, 0, NP-1, 1'b0);
    send_pairs(1, 0, NP-1, 1'b0);
    chk("ovf_before_third", 64'(bus.overflow), 64'd0);
    send_pairs(2, 0, 0, 1'b0);
    @(negedge clk);
    chk("ovf_after_pair0", 64'(bus.overflow), 64'd1);
    send_pairs(2, 1, NP-1, 1'b0);
    bus.out_ready = 1'b1;
    wait_last_xfer("ovf_first_last");
    send_pairs(3, 0, NP-1, 1'b0);
    check_outputs(3*N, "overflow", 1'b0);
    chk("ovf_sticky", 64'(bus.overflow), 64'd1);

    // Reset in the middle of a drain.
    fill_rand(0);
    send_pairs(0, 0, NP-1, 1'b0);
    for (int c = 0; c < 200; c++) begin
      if (bus.out_valid === 1'b1 && bus.out_index === LOG2N'(20)) break;
      @(posedge clk); #1;
    end
    chk("mid_drain_at_bin20", 64'(bus.out_index), 64'd20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_drain_valid",    64'(bus.out_valid), 64'd0);
    chk("rst_drain_overflow", 64'(bus.overflow),  64'd0);
    got.delete();
    stamps.delete();
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("no_partial_frame", 64'(got.size()), 64'd0);
    fill_rand(1);
    push_exp(1);
    send_pairs(1, 0, NP-1, 1'b0);
    check_outputs(N, "after_rst", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
